// File: rtl/complex_div_seq_if.sv
// Handshake bus for complex_div_seq: operand channel in, result channel out.
// The master modport is the producer/consumer side, the slave modport is the divider.
interface complex_div_seq_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [2*W-1:0] divisor;
  logic [2*W-1:0] quotient;
  logic           out_valid;
  logic           out_ready;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, quotient, out_valid, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, quotient, out_valid, div_by_zero, overflow
  );
endinterface

// File: rtl/complex_div_seq.sv
// Sequential complex divider: conj-multiply, then one shared restoring divider
// run over the real and then the imaginary numerator, with per-component saturation.
module complex_div_seq #(
  parameter int W    = 16,
  parameter int FRAC = 0
) (
  input  logic               clk,
  input  logic               rst,
  complex_div_seq_if.slave   bus
);
  localparam int DW = 2 * W;
  localparam int PW = 2 * W + 1;
  localparam int N  = PW + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [N-1:0]  LIM_NEG  = N'(1) << (W - 1);
  localparam logic [N-1:0]  LIM_POS  = LIM_NEG - N'(1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_VAL  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, PROD, MULT, DIV_RE, DIV_IM, DONE
  } state_t;

  state_t         state_q;
  logic signed [W-1:0] aRe_q, aIm_q, bRe_q, bIm_q;
  logic [PW-1:0]  nRe_q, nIm_q;
  logic [DW-1:0]  d_q;
  logic [DW-1:0]  rem_q;
  logic [N-1:0]   num_q;
  logic           neg_q;
  logic [CW-1:0]  cnt_q;
  logic [DW-1:0]  quotient_q;
  logic           dbz_q;
  logic           ovf_q;
  logic           outValid_q;
  logic           inReady_q;

  logic signed [DW-1:0] pRr, pIi, pIr, pRi, pBr2, pBi2;
  logic signed [PW-1:0] prodRe, prodIm;
  logic [DW-1:0]  dSum;
  logic [PW-1:0]  selNum, selMag;
  logic           selNeg;
  logic [N-1:0]   numLoad;
  logic [DW:0]    trial;
  logic           geq;
  logic [DW-1:0]  remNext;
  logic [N-1:0]   numNext;
  logic [W:0]     satOut;

  // Full-width signed products; the (2W+1)-bit sums absorb the -2^(W-1) corner cases.
  assign pRr    = aRe_q * bRe_q;
  assign pIi    = aIm_q * bIm_q;
  assign pIr    = aIm_q * bRe_q;
  assign pRi    = aRe_q * bIm_q;
  assign pBr2   = bRe_q * bRe_q;
  assign pBi2   = bIm_q * bIm_q;
  assign prodRe = $signed({pRr[DW-1], pRr}) + $signed({pIi[DW-1], pIi});
  assign prodIm = $signed({pIr[DW-1], pIr}) - $signed({pRi[DW-1], pRi});
  assign dSum   = pBr2 + pBi2;

  assign selNum  = (state_q == MULT) ? nRe_q : nIm_q;
  assign selNeg  = selNum[PW-1];
  assign selMag  = selNeg ? ((~selNum) + PW'(1)) : selNum;
  assign numLoad = loadNum(selMag);

  // One restoring step: shift in the next numerator bit, subtract when it fits.
  assign trial   = {rem_q, num_q[N-1]};
  assign geq     = trial >= {1'b0, d_q};
  assign remNext = geq ? DW'(trial - {1'b0, d_q}) : trial[DW-1:0];
  assign numNext = {num_q[N-2:0], geq};
  assign satOut  = saturate(numNext, neg_q);

  function automatic logic [N-1:0] loadNum(input logic [PW-1:0] mag);
    logic [N-1:0] t;
    t = '0;
    t[PW-1:0] = mag;
    return t << FRAC;
  endfunction

  function automatic logic [W:0] saturate(input logic [N-1:0] mag, input logic neg);
    logic [W:0] r;
    if (neg) begin
      if (mag > LIM_NEG) r = {1'b1, MIN_VAL};
      else               r = {1'b0, -mag[W-1:0]};
    end else begin
      if (mag > LIM_POS) r = {1'b1, MAX_VAL};
      else               r = {1'b0, mag[W-1:0]};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      aRe_q      <= '0;
      aIm_q      <= '0;
      bRe_q      <= '0;
      bIm_q      <= '0;
      nRe_q      <= '0;
      nIm_q      <= '0;
      d_q        <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      quotient_q <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            aRe_q     <= bus.dividend[DW-1:W];
            aIm_q     <= bus.dividend[W-1:0];
            bRe_q     <= bus.divisor[DW-1:W];
            bIm_q     <= bus.divisor[W-1:0];
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            inReady_q <= 1'b0;
            state_q   <= PROD;
          end
        end
        // Products are registered so the multipliers never feed the divider directly.
        PROD: begin
          nRe_q   <= prodRe;
          nIm_q   <= prodIm;
          d_q     <= dSum;
          state_q <= MULT;
        end
        MULT: begin
          if (d_q == '0) begin
            quotient_q <= '0;
            dbz_q      <= 1'b1;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            num_q   <= numLoad;
            rem_q   <= '0;
            neg_q   <= selNeg;
            cnt_q   <= '0;
            state_q <= DIV_RE;
          end
        end
        DIV_RE: begin
          if (cnt_q == LAST_CNT) begin
            quotient_q[DW-1:W] <= satOut[W-1:0];
            ovf_q   <= satOut[W];
            num_q   <= numLoad;
            rem_q   <= '0;
            neg_q   <= selNeg;
            cnt_q   <= '0;
            state_q <= DIV_IM;
          end else begin
            num_q <= numNext;
            rem_q <= remNext;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DIV_IM: begin
          if (cnt_q == LAST_CNT) begin
            quotient_q[W-1:0] <= satOut[W-1:0];
            ovf_q      <= ovf_q | satOut[W];
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            num_q <= numNext;
            rem_q <= remNext;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = inReady_q;
  assign bus.quotient    = quotient_q;
  assign bus.out_valid   = outValid_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_complex_div_seq.sv
// Scoreboard bench for complex_div_seq: a FRAC=0 and a FRAC=1 instance, expected
// results from an integer reference model queued at stimulus time and popped on output.
module tb_complex_div_seq;
  localparam int W = 16;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   nCompared = 0;
  int   nMismatch = 0;

  always #5 clk = ~clk;

  complex_div_seq_if #(.W(W)) bus0 ();
  complex_div_seq_if #(.W(W)) bus1 ();

  complex_div_seq #(.W(W), .FRAC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  complex_div_seq #(.W(W), .FRAC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [15:0] clip(input longint v, output logic o);
    o = 1'b0;
    if (v > 32767) begin
      o = 1'b1;
      v = 32767;
    end else if (v < -32768) begin
      o = 1'b1;
      v = -32768;
    end
    return v[15:0];
  endfunction

  // Reference: exact conj-multiply in 64-bit, C-style division truncates toward zero.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int frac);
    exp_t   e;
    longint ar, ai, br, bi, nr, ni, d;
    logic   o1, o2;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (d == 0) begin
      e.q   = 32'h0;
      e.dbz = 1'b1;
      e.lat = 2;
    end else begin
      e.q[31:16] = clip((nr * (longint'(1) << frac)) / d, o1);
      e.q[15:0]  = clip((ni * (longint'(1) << frac)) / d, o2);
      e.ovf = o1 | o2;
      e.lat = 2 * (2 * W + 1 + frac) + 2;
    end
    return e;
  endfunction

  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] q, output logic dbz, output logic ovf,
                               output int lat);
    sb.push_back(model(a, b, sel));
    if (sel == 0) begin
      bus0.dividend = a;
      bus0.divisor  = b;
      bus0.in_valid = 1'b1;
    end else begin
      bus1.dividend = a;
      bus1.divisor  = b;
      bus1.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (((sel == 0) ? bus0.out_valid : bus1.out_valid) === 1'b1) begin
        lat = c;
        break;
      end
    end
    q   = (sel == 0) ? bus0.quotient    : bus1.quotient;
    dbz = (sel == 0) ? bus0.div_by_zero : bus1.div_by_zero;
    ovf = (sel == 0) ? bus0.overflow    : bus1.overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.dividend = '0; bus0.divisor = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.dividend = '0; bus1.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    nCompared++; if (bus0.in_ready !== 1'b1) begin nMismatch++; $display("[TB] FAIL reset in_ready: got %b expected 1", bus0.in_ready); end
    nCompared++; if (bus0.out_valid !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset out_valid: got %b expected 0", bus0.out_valid); end
    nCompared++; if (bus0.quotient !== 32'h0) begin nMismatch++; $display("[TB] FAIL reset quotient: got %h expected 0", bus0.quotient); end
    nCompared++; if ({bus0.div_by_zero, bus0.overflow} !== 2'b00) begin nMismatch++; $display("[TB] FAIL reset flags: got %b expected 00", {bus0.div_by_zero, bus0.overflow}); end
    nCompared++; if (bus1.in_ready !== 1'b1) begin nMismatch++; $display("[TB] FAIL reset frac in_ready: got %b expected 1", bus1.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] tA[9];
    logic [31:0] tB[9];
    logic [31:0] q;
    logic        dbz, ovf;
    int          lat;
    exp_t        e;
    tA = '{32'h006400C8, 32'h00010001, 32'hFFF90000, 32'h80000000, 32'h00050005,
           32'h80008000, 32'h80008000, 32'h7FFF7FFF, 32'hFFFF0000};
    tB = '{32'h000A0000, 32'h0001FFFF, 32'h00020000, 32'hFFFF0000, 32'h00000000,
           32'h80008000, 32'h00010000, 32'h00000001, 32'h00050000};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, tA[i], tB[i], q, dbz, ovf, lat);
      e = sb.pop_front();
      nCompared++; if (q !== e.q) begin nMismatch++; $display("[TB] FAIL directed[%0d] quotient: got %h expected %h", i, q, e.q); end
      nCompared++; if (dbz !== e.dbz) begin nMismatch++; $display("[TB] FAIL directed[%0d] div_by_zero: got %b expected %b", i, dbz, e.dbz); end
      nCompared++; if (ovf !== e.ovf) begin nMismatch++; $display("[TB] FAIL directed[%0d] overflow: got %b expected %b", i, ovf, e.ovf); end
      nCompared++; if (lat !== e.lat) begin nMismatch++; $display("[TB] FAIL directed[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      @(posedge clk); #1;
      nCompared++; if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin nMismatch++; $display("[TB] FAIL directed[%0d] transfer: got out_valid,in_ready=%b expected 01", i, {bus0.out_valid, bus0.in_ready}); end
    end
  endtask

  task automatic test_frac();
    logic [31:0] q;
    logic        dbz, ovf;
    int          lat;
    exp_t        e;
    applyStimulus(1, 32'hFFF90000, 32'h00020000, q, dbz, ovf, lat);
    e = sb.pop_front();
    nCompared++; if (q !== 32'hFFF90000) begin nMismatch++; $display("[TB] FAIL frac quotient: got %h expected fff90000", q); end
    nCompared++; if (q !== e.q) begin nMismatch++; $display("[TB] FAIL frac model quotient: got %h expected %h", q, e.q); end
    nCompared++; if ({dbz, ovf} !== {e.dbz, e.ovf}) begin nMismatch++; $display("[TB] FAIL frac flags: got %b expected %b", {dbz, ovf}, {e.dbz, e.ovf}); end
    nCompared++; if (lat !== e.lat) begin nMismatch++; $display("[TB] FAIL frac latency: got %0d expected %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] q;
    logic        dbz, ovf;
    int          lat;
    exp_t        e;
    bus0.out_ready = 1'b0;
    applyStimulus(0, 32'h006400C8, 32'h000A0000, q, dbz, ovf, lat);
    e = sb.pop_front();
    nCompared++; if (q !== e.q) begin nMismatch++; $display("[TB] FAIL bp quotient: got %h expected %h", q, e.q); end
    nCompared++; if (lat !== e.lat) begin nMismatch++; $display("[TB] FAIL bp latency: got %0d expected %0d", lat, e.lat); end
    for (int c = 0; c < 20; c++) begin
      bus0.in_valid = c[0];
      bus0.dividend = 32'h12345678;
      bus0.divisor  = 32'h00030003;
      @(posedge clk); #1;
      nCompared++; if ({bus0.out_valid, bus0.in_ready} !== 2'b10) begin nMismatch++; $display("[TB] FAIL bp hold[%0d] out_valid,in_ready: got %b expected 10", c, {bus0.out_valid, bus0.in_ready}); end
      nCompared++; if (bus0.quotient !== e.q) begin nMismatch++; $display("[TB] FAIL bp hold[%0d] quotient: got %h expected %h", c, bus0.quotient, e.q); end
      nCompared++; if ({bus0.div_by_zero, bus0.overflow} !== {e.dbz, e.ovf}) begin nMismatch++; $display("[TB] FAIL bp hold[%0d] flags: got %b expected %b", c, {bus0.div_by_zero, bus0.overflow}, {e.dbz, e.ovf}); end
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    nCompared++; if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin nMismatch++; $display("[TB] FAIL bp release: got out_valid,in_ready=%b expected 01", {bus0.out_valid, bus0.in_ready}); end
    repeat (4) @(posedge clk);
    #1;
    nCompared++; if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin nMismatch++; $display("[TB] FAIL bp ignored pulses: got out_valid,in_ready=%b expected 01", {bus0.out_valid, bus0.in_ready}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    logic        dbz, ovf;
    int          lat;
    exp_t        e;
    bus0.dividend = 32'h80000000;
    bus0.divisor  = 32'hFFFF0000;
    bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    nCompared++; if (bus0.out_valid !== 1'b0) begin nMismatch++; $display("[TB] FAIL midreset out_valid: got %b expected 0", bus0.out_valid); end
    nCompared++; if (bus0.quotient !== 32'h0) begin nMismatch++; $display("[TB] FAIL midreset quotient: got %h expected 0", bus0.quotient); end
    nCompared++; if ({bus0.div_by_zero, bus0.overflow} !== 2'b00) begin nMismatch++; $display("[TB] FAIL midreset flags: got %b expected 00", {bus0.div_by_zero, bus0.overflow}); end
    nCompared++; if (bus0.in_ready !== 1'b1) begin nMismatch++; $display("[TB] FAIL midreset in_ready: got %b expected 1", bus0.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, 32'h00010001, 32'h0001FFFF, q, dbz, ovf, lat);
    e = sb.pop_front();
    nCompared++; if (q !== e.q) begin nMismatch++; $display("[TB] FAIL midreset rerun quotient: got %h expected %h", q, e.q); end
    nCompared++; if ({dbz, ovf} !== {e.dbz, e.ovf}) begin nMismatch++; $display("[TB] FAIL midreset rerun flags: got %b expected %b", {dbz, ovf}, {e.dbz, e.ovf}); end
    nCompared++; if (lat !== e.lat) begin nMismatch++; $display("[TB] FAIL midreset rerun latency: got %0d expected %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, q;
    logic        dbz, ovf;
    int          lat, vr, vi;
    exp_t        e;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      if (i % 3 == 0) begin
        b = $urandom;
      end else begin
        vr = int'($urandom_range(0, 16)) - 8;
        vi = int'($urandom_range(0, 16)) - 8;
        b  = {vr[15:0], vi[15:0]};
      end
      applyStimulus(0, a, b, q, dbz, ovf, lat);
      e = sb.pop_front();
      nCompared++; if (q !== e.q) begin nMismatch++; $display("[TB] FAIL random[%0d] %h/%h quotient: got %h expected %h", i, a, b, q, e.q); end
      nCompared++; if ({dbz, ovf} !== {e.dbz, e.ovf}) begin nMismatch++; $display("[TB] FAIL random[%0d] flags: got %b expected %b", i, {dbz, ovf}, {e.dbz, e.ovf}); end
      nCompared++; if (lat !== e.lat) begin nMismatch++; $display("[TB] FAIL random[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    $display("[TB] starting complex_div_seq bench");
    test_reset();
    test_directed();
    test_frac();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
